dsec_in_packer: RTL and testbench
=================================

DSEC_IN_PACKER -- requirements
Module: dsec_in_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock, all state updates on it; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the following ports:
- byte_in  input  8  upstream byte
- byte_valid  input  1  byte_in valid this cycle
- byte_rdy  output  1  packer accepts byte_in this cycle
- flush  input  1  zero-pad and emit the partial word
- key_load  input  1  the next 3 assembled words are key words
- rdy  input  1  DSEC core ready for a word
- data_in  output  64  word to DSEC core
- in_valid  output  1  one-cycle strobe qualifying data_in
- key_config  output  1  DSEC key-configuration mode
- error  output  1  sticky protocol error
- word_count  output  16  count of data (non-key) words emitted

Function
REQ-003 A byte SHALL be accepted on a cycle where byte_valid=1 and byte_rdy=1.
REQ-004 Accepted bytes SHALL pack big-endian: 1st byte to [63:56], 8th byte to [7:0]; byte counter cnt (3 bits) SHALL increment per accept and wrap 7->0.
REQ-005 On the 8th accept, the assembled word SHALL transfer to the output register on the same edge, setting pending=1 and clearing assembly to zero, if pending=0 or pending is cleared that same cycle.
REQ-006 If the 8th byte completes while pending stays 1, the word SHALL be held in assembly (full=1), and byte_rdy SHALL be 0 until it transfers.
REQ-007 byte_rdy SHALL equal NOT full; it SHALL be combinational from registered state only.
REQ-008 in_valid SHALL assert for exactly one cycle, registered, on the cycle after pending=1 and rdy=1 are sampled; pending SHALL clear on that same edge.
REQ-009 in_valid SHALL never be high on two consecutive cycles; a second word waits at least one idle cycle.
REQ-010 data_in SHALL hold the output-register value, stable from the in_valid cycle until the next transfer.
REQ-011 Flush SHALL apply as follows:
- flush=1 with cnt>0 (after counting any byte accepted that cycle) SHALL zero-pad the unfilled bytes, treat the word as complete per REQ-005/006, and reset cnt to 0.
- flush with cnt=0 SHALL have no effect.
- flush while full=1 SHALL be ignored.
REQ-012 key_load=1 with cnt=0, full=0, pending=0 and key mode off SHALL enter key mode with key_left=3.
REQ-013 key_config SHALL rise the cycle after an accepted key_load and stay high through the in_valid of the 3rd key word, falling the cycle after it.
REQ-014 In key mode each emitted word SHALL decrement key_left; key words SHALL NOT increment word_count.
REQ-015 key_load under any other condition SHALL be ignored and SHALL set error.
REQ-016 error SHALL be sticky until rst.
REQ-017 word_count SHALL increment by 1 per in_valid of a non-key word and wrap 0xFFFF->0x0000.
REQ-018 Simultaneous events SHALL resolve as follows:
- A byte accepted on the same cycle a transfer frees the output register SHALL be captured normally, with no loss.
- A flush and an 8th byte on the same cycle SHALL complete the word once, with no padding added.
REQ-019 rdy deasserting while pending=1 SHALL hold the word indefinitely, with no timeout and no drop.

Reset
REQ-020 On rst=1 at a rising edge, all of the following SHALL return to the values given:
- cnt=0, full=0, pending=0, key mode off, key_left=0
- data_in=0, in_valid=0, key_config=0, error=0, word_count=0
- byte_rdy=1 from the following cycle
REQ-021 rst asserted mid-word or mid-key-sequence SHALL discard all partial, pending and key state with no in_valid emitted.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic word: rdy=1; bytes 01..08 each cycle -> one in_valid, data_in=0x0102030405060708, word_count=1.
- Key load: key_load; 24 bytes 0x11x8,0x22x8,0x33x8; rdy=1 -> three in_valid pulses 0x1111111111111111, 0x2222222222222222, 0x3333333333333333; key_config high throughout, low after; word_count=0.
- Backpressure: rdy=0; 16 bytes 0xA0..0xAF -> byte_rdy=0 after 16th; no in_valid; rdy=1 -> two pulses, non-consecutive, in order; byte_rdy returns to 1.
- Flush: bytes 0xDE,0xAD then flush -> data_in=0xDEAD000000000000, one in_valid; flush at cnt=0 -> nothing.
- Error: 3 bytes then key_load -> error=1, key_config stays 0; next 5 bytes -> normal data word.
- Reset: reset after 5 bytes -> outputs at reset values; next 8 bytes form a clean word.

Source files
------------

// File: rtl/dsec_in_packer.sv
// dsec_in_packer: packs upstream bytes big-endian into 64-bit words for the DSEC core, with key-load sequencing
module dsec_in_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_rdy,
  input  logic        flush,
  input  logic        key_load,
  input  logic        rdy,
  output logic [63:0] data_in,
  output logic        in_valid,
  output logic        key_config,
  output logic        error,
  output logic [15:0] word_count
);
  logic [63:0] word_q, word_d, obuf;
  logic [2:0]  cnt;
  logic [1:0]  key_left;
  logic [3:0]  fill;
  logic        full, pending, key_mode;
  logic        accept, complete, emit, free, key_ok;
  assign byte_rdy   = ~full;
  assign key_config = key_mode;
  always_comb begin
    accept   = byte_valid & ~full;
    fill     = {1'b0, cnt} + {3'b0, accept};
    word_d   = accept ? word_q | ({56'b0, byte_in} << (6'd56 - {cnt, 3'b0})) : word_q;
    complete = fill[3] | (flush & ~full & (fill != 4'd0));
    emit     = pending & rdy & ~in_valid;
    free     = ~pending | emit;
    key_ok   = key_load & (cnt == 3'd0) & ~full & ~pending & ~key_mode;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      obuf       <= '0;
      cnt        <= '0;
      full       <= 1'b0;
      pending    <= 1'b0;
      key_mode   <= 1'b0;
      key_left   <= '0;
      data_in    <= '0;
      in_valid   <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      in_valid <= emit;
      cnt      <= complete ? 3'd0 : fill[2:0];
      if (emit) begin
        data_in <= obuf;
        if (key_mode && key_left != 2'd0) key_left <= key_left - 2'd1;
        else word_count <= word_count + 16'd1;
      end
      // key mode stays up through the last key word's strobe, dropping one cycle later
      if (in_valid && key_mode && key_left == 2'd0) key_mode <= 1'b0;
      if (key_ok) begin
        key_mode <= 1'b1;
        key_left <= 2'd3;
      end
      if (key_load && !key_ok) error <= 1'b1;
      if (full && free) begin
        obuf    <= word_q;
        pending <= 1'b1;
        full    <= 1'b0;
        word_q  <= '0;
      end else if (complete && free) begin
        obuf    <= word_d;
        pending <= 1'b1;
        word_q  <= '0;
      end else if (complete) begin
        full   <= 1'b1;
        word_q <= word_d;
      end else begin
        word_q <= word_d;
        if (emit) pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dsec_in_packer.sv
// tb_dsec_in_packer: directed and randomized checks of dsec_in_packer against a byte-queue reference model
module tb_dsec_in_packer;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0, flush = 1'b0, key_load = 1'b0, rdy = 1'b0;
  logic        byte_rdy, in_valid, key_config, error;
  logic [63:0] data_in;
  logic [15:0] word_count;

  dsec_in_packer dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_rdy(byte_rdy),
    .flush(flush), .key_load(key_load), .rdy(rdy), .data_in(data_in), .in_valid(in_valid),
    .key_config(key_config), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] w; bit key;} word_t;
  word_t       expq[$];
  logic [7:0]  part[$];
  int          tests = 0, fails = 0, n_iv = 0, key_tag = 0, key_emit = 0;
  bit          exp_kc = 0, exp_err = 0, prev_iv = 0;
  logic [15:0] exp_wc = '0;
  logic [63:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, let the edge happen, update the model, compare
  task automatic cyc(input bit bv, input logic [7:0] b, input bit fl, input bit kl, input bit r);
    bit acc, kok, drop;
    word_t e;
    logic [63:0] w;
    byte_valid = bv; byte_in = b; flush = fl; key_load = kl; rdy = r;
    acc = bv && (byte_rdy === 1'b1);
    kok = kl && part.size() == 0 && expq.size() == 0 && !exp_kc;
    @(posedge clk); #1;
    if (kl) begin
      if (kok) begin exp_kc = 1; key_tag = 3; key_emit = 3; end
      else exp_err = 1;
    end
    if (acc) part.push_back(b);
    if (part.size() == 8 || (fl && part.size() > 0)) begin
      w = '0;
      foreach (part[i]) w[63-8*i -: 8] = part[i];
      expq.push_back('{w, key_tag > 0});
      if (key_tag > 0) key_tag--;
      part.delete();
    end
    drop = 0;
    if (in_valid === 1'b1) begin
      n_iv++;
      chk("no_back_to_back", 64'(prev_iv), 64'd0);
      chk("iv_has_word", 64'(expq.size() != 0), 64'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("data_in", data_in, e.w);
        last_data = data_in;
        if (e.key) begin key_emit--; drop = (key_emit == 0); end
        else exp_wc++;
      end
    end
    prev_iv = (in_valid === 1'b1);
    chk("key_config", 64'(key_config), 64'(exp_kc));
    chk("error", 64'(error), 64'(exp_err));
    chk("word_count", 64'(word_count), 64'(exp_wc));
    if (drop) exp_kc = 0;
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cyc(0, 8'h00, 0, 0, r);
  endtask

  task automatic do_reset();
    byte_valid = 0; flush = 0; key_load = 0; rdy = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_data_in", data_in, 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_key_config", 64'(key_config), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_byte_rdy", 64'(byte_rdy), 64'd1);
    expq.delete(); part.delete();
    key_tag = 0; key_emit = 0; exp_kc = 0; exp_err = 0; prev_iv = 0; exp_wc = '0;
  endtask

  initial begin
    int base;
    do_reset();
    // basic word
    base = n_iv;
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, 1);
    idle(4, 1);
    chk("basic_count", 64'(n_iv - base), 64'd1);
    chk("basic_word", last_data, 64'h0102030405060708);
    chk("basic_wc", 64'(word_count), 64'd1);
    // key load
    base = n_iv;
    cyc(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 24; i++) cyc(1, (i < 8) ? 8'h11 : (i < 16) ? 8'h22 : 8'h33, 0, 0, 1);
    idle(6, 1);
    chk("key_count", 64'(n_iv - base), 64'd3);
    chk("key_last", last_data, 64'h3333333333333333);
    chk("key_cfg_after", 64'(key_config), 64'd0);
    chk("key_wc", 64'(word_count), 64'd1);
    // backpressure
    base = n_iv;
    for (int i = 0; i < 16; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 0);
    chk("bp_byte_rdy_low", 64'(byte_rdy), 64'd0);
    idle(3, 0);
    chk("bp_no_iv", 64'(n_iv - base), 64'd0);
    idle(6, 1);
    chk("bp_count", 64'(n_iv - base), 64'd2);
    chk("bp_last", last_data, 64'hA8A9AAABACADAEAF);
    chk("bp_byte_rdy_back", 64'(byte_rdy), 64'd1);
    // flush
    base = n_iv;
    cyc(1, 8'hDE, 0, 0, 1);
    cyc(1, 8'hAD, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    idle(4, 1);
    chk("flush_count", 64'(n_iv - base), 64'd1);
    chk("flush_word", last_data, 64'hDEAD000000000000);
    base = n_iv;
    cyc(0, 8'h00, 1, 0, 1);
    idle(4, 1);
    chk("flush_empty", 64'(n_iv - base), 64'd0);
    // flush together with the 8th byte: no extra padding word
    base = n_iv;
    for (int i = 0; i < 7; i++) cyc(1, 8'hC0 + 8'(i), 0, 0, 1);
    cyc(1, 8'hC7, 1, 0, 1);
    idle(4, 1);
    chk("flush8_count", 64'(n_iv - base), 64'd1);
    chk("flush8_word", last_data, 64'hC0C1C2C3C4C5C6C7);
    // error
    for (int i = 0; i < 3; i++) cyc(1, 8'h51 + 8'(i), 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    chk("err_set", 64'(error), 64'd1);
    chk("err_no_key", 64'(key_config), 64'd0);
    for (int i = 3; i < 8; i++) cyc(1, 8'h51 + 8'(i), 0, 0, 1);
    idle(4, 1);
    chk("err_word", last_data, 64'h5152535455565758);
    chk("err_sticky", 64'(error), 64'd1);
    // reset mid-word
    for (int i = 0; i < 5; i++) cyc(1, 8'h70 + 8'(i), 0, 0, 0);
    do_reset();
    base = n_iv;
    for (int i = 0; i < 8; i++) cyc(1, 8'h80 + 8'(i), 0, 0, 1);
    idle(4, 1);
    chk("rst_clean_count", 64'(n_iv - base), 64'd1);
    chk("rst_clean_word", last_data, 64'h8081828384858687);
    // randomized traffic
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    cyc(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 60 && expq.size() != 0; i++) cyc(0, 8'h00, 0, 0, 1);
    idle(3, 1);
    chk("drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
